// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : i2c_pkg
//  Description : Shared types and constants for the I2C target / initiator
//                pair on the HDMI transmitter configuration path.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  // Protocol states of the register-file target.
  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ADDR       = 4'd1,
    ST_ADDR_ACK   = 4'd2,
    ST_REG_ADDR   = 4'd3,
    ST_REG_ACK    = 4'd4,
    ST_WRITE_DATA = 4'd5,
    ST_WRITE_ACK  = 4'd6,
    ST_READ_DATA  = 4'd7,
    ST_READ_ACK   = 4'd8,
    ST_IGNORE     = 4'd9
  } i2c_state_t;

  // Value of the R/W bit in the address byte.
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  // 7-bit bus address of the ADV7513 HDMI transmitter (0x72 / 0x73 on the wire).
  localparam logic [6:0] ADV7513_ADDR = 7'h39;

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_line_sync
//  Description : Synchronizes SCL/SDA into the system clock domain and derives
//                SCL edges plus START/STOP line conditions. Shared with the
//                initiator, which uses sda_sample for arbitration checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_25,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_sample
);

  // Fewer than two flops would not be a synchronizer, so clamp.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] scl_sync;
  logic [STAGES-1:0] sda_sync;
  logic              scl_prev;
  logic              sda_prev;
  logic              scl_cur;
  logic              sda_cur;

  // Synchronizer chains plus one history flop per line; idle bus level is high.
  always_ff @(posedge clock_25) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[STAGES-2:0], sda_in};
      scl_prev <= scl_sync[STAGES-1];
      sda_prev <= sda_sync[STAGES-1];
    end
  end

  assign scl_cur    = scl_sync[STAGES-1];
  assign sda_cur    = sda_sync[STAGES-1];
  assign scl_rise   = scl_cur & ~scl_prev;
  assign scl_fall   = ~scl_cur & scl_prev;
  // START/STOP only count while SCL is steadily high across both samples.
  assign start_det  = scl_cur & scl_prev & sda_prev & ~sda_cur;
  assign stop_det   = scl_cur & scl_prev & ~sda_prev & sda_cur;
  assign sda_sample = sda_cur;

endmodule
`default_nettype wire

// File: rtl/i2c_target_regs.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_regs
//  Description : I2C target with a 256 x 8 register file, emulating the HDMI
//                transmitter configuration port. Oversampled, no clock
//                stretching, open-drain SDA.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = ADV7513_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic       i2c_serial_clock,
  inout  wire        i2c_serial_data,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_sample;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clock_25   (clock_25),
    .reset      (reset),
    .scl_in     (i2c_serial_clock),
    .sda_in     (i2c_serial_data),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .sda_sample (sda_sample)
  );

  i2c_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_low_q, sda_low_d;
  logic       busy_d;
  logic       rw_q, rw_d;
  logic       wr_strobe_d;
  logic [7:0] wr_addr_d;
  logic [7:0] wr_data_d;
  logic       reg_we;

  logic [7:0] regs [256];
  logic [7:0] ptr_plus1;
  logic [7:0] byte_in;
  logic [7:0] rd_cur;
  logic [7:0] rd_next;
  logic       addr_match;

  assign ptr_plus1  = ptr_q + 8'd1;
  assign byte_in    = {shift_q[6:0], sda_sample};
  assign rd_cur     = regs[ptr_q];
  assign rd_next    = regs[ptr_plus1];
  // General call (0x00) is never answered, even if TARGET_ADDR were set to 0.
  assign addr_match = (byte_in[7:1] == TARGET_ADDR) && (byte_in[7:1] != 7'h00);

  // Open drain: only ever pull low or release.
  assign i2c_serial_data = sda_low_q ? 1'b0 : 1'bz;

  // State register.
  always_ff @(posedge clock_25) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath decisions; line conditions override bit edges.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    ptr_d       = ptr_q;
    sda_low_d   = sda_low_q;
    busy_d      = busy;
    rw_d        = rw_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    reg_we      = 1'b0;

    if (stop_det) begin
      state_d   = ST_IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      sda_low_d = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (addr_match) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = byte_in[0];
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end
        // ACK states: first SCL fall pulls SDA low, second one releases it.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else if (rw_q == I2C_READ) begin
              // First read bit goes out on the same fall that ends the ACK.
              state_d   = ST_READ_DATA;
              shift_d   = rd_cur;
              sda_low_d = ~rd_cur[7];
            end else if (rw_q == I2C_WRITE) begin
              state_d   = ST_REG_ADDR;
              sda_low_d = 1'b0;
            end
          end
        end
        ST_REG_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              ptr_d     = byte_in;
              state_d   = ST_REG_ACK;
            end
          end
        end
        ST_REG_ACK: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              state_d   = ST_WRITE_DATA;
            end
          end
        end
        ST_WRITE_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d   = 4'd0;
              reg_we      = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = byte_in;
              state_d     = ST_WRITE_ACK;
            end
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              ptr_d     = ptr_plus1;
              state_d   = ST_WRITE_DATA;
            end
          end
        end
        // bit_cnt counts SCL rises; a fall with count 0 means the byte was
        // loaded at a rise (after an ACK) and its MSB is still to be shown.
        ST_READ_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = 4'd0;
              sda_low_d = 1'b0;
              state_d   = ST_READ_ACK;
            end else if (bit_cnt_q == 4'd0) begin
              sda_low_d = ~shift_q[7];
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_low_d = ~shift_q[6];
            end
          end
        end
        ST_READ_ACK: begin
          if (scl_rise) begin
            if (!sda_sample) begin
              ptr_d     = ptr_plus1;
              shift_d   = rd_next;
              bit_cnt_d = 4'd0;
              state_d   = ST_READ_DATA;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        default: begin
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock_25) begin
    if (!reset) begin
      shift_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
      ptr_q     <= 8'h00;
      sda_low_q <= 1'b0;
      busy      <= 1'b0;
      rw_q      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ptr_q     <= ptr_d;
      sda_low_q <= sda_low_d;
      busy      <= busy_d;
      rw_q      <= rw_d;
      wr_strobe <= wr_strobe_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
    end
  end

  // Register file, cleared by reset.
  always_ff @(posedge clock_25) begin
    if (!reset)      regs <= '{default: 8'h00};
    else if (reg_we) regs[ptr_q] <= byte_in;
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_target_regs
//  Description : Bench for i2c_target_regs: bus-level initiator tasks and a
//                transaction-level register-file model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target_regs;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       scl    = 1'b1;
  logic       sda_oe = 1'b0;
  wire        sda_bus;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  assign sda_bus = sda_oe ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #20 clk = ~clk;

  i2c_target_regs #(
    .TARGET_ADDR (7'h39),
    .SYNC_STAGES (2)
  ) dut (
    .clock_25         (clk),
    .reset            (rst_n),
    .i2c_serial_clock (scl),
    .i2c_serial_data  (sda_bus),
    .wr_strobe        (wr_strobe),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .busy             (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int q        = 10;

  logic [7:0]  model_regs [256];
  logic [7:0]  model_ptr;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];

  // Record every write strobe.
  always @(negedge clk) begin
    if (rst_n && wr_strobe) obs_q.push_back({wr_addr, wr_data});
  end

  // Count cycles the target pulls SDA low, and SDA changes while SCL is high
  // that the initiator did not cause.
  int   dut_low_cnt = 0;
  int   rule_viol   = 0;
  logic scl_p = 1'b1, oe_p = 1'b0, bus_p = 1'b1;
  always @(posedge clk) begin
    #1;
    if (!sda_oe && sda_bus === 1'b0) dut_low_cnt <= dut_low_cnt + 1;
    if (rst_n && scl && scl_p && (sda_oe == oe_p) && (sda_bus !== bus_p))
      rule_viol <= rule_viol + 1;
    scl_p <= scl;
    oe_p  <= sda_oe;
    bus_p <= sda_bus;
  end

  initial begin
    #8_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- bus-level initiator ----------------
  task automatic wait_q();
    repeat (q) @(negedge clk);
  endtask

  task automatic m_start();
    sda_oe = 1'b0; wait_q();
    scl = 1'b1;    wait_q();
    sda_oe = 1'b1; wait_q();
    scl = 1'b0;    wait_q();
  endtask

  task automatic m_stop();
    sda_oe = 1'b1; wait_q();
    scl = 1'b1;    wait_q();
    sda_oe = 1'b0; wait_q();
  endtask

  task automatic m_bit_w(input logic b);
    sda_oe = ~b; wait_q();
    scl = 1'b1;  wait_q(); wait_q();
    scl = 1'b0;  wait_q();
  endtask

  task automatic m_bit_r(output logic b);
    sda_oe = 1'b0; wait_q();
    scl = 1'b1;    wait_q();
    b = (sda_bus !== 1'b0);
    wait_q();
    scl = 1'b0;    wait_q();
  endtask

  task automatic m_wbyte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) m_bit_w(d[i]);
    m_bit_r(b);
    ack = ~b;
  endtask

  task automatic m_rbyte(output logic [7:0] d, input logic ack);
    logic b;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      m_bit_r(b);
      d[i] = b;
    end
    m_bit_w(~ack);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
    model_ptr = 8'h00;
    n_checks++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
    n_checks++; if (wr_addr !== 8'h00) begin n_fail++; $display("FAIL reset_wr_addr: got %h expected 00", wr_addr); end
    n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b expected 1 (released)", sda_bus); end
  endtask

  task automatic test_write_single();
    logic a;
    logic [7:0] seq [3] = '{8'h72, 8'h41, 8'h10};
    q = 62;
    obs_q.delete();
    m_start();
    for (int i = 0; i < 3; i++) begin
      m_wbyte(seq[i], a);
      n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL write1_ack[%0d]: got ack=%b expected 1", i, a); end
      if (i == 0) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write1_busy: got %b expected 1", busy); end
      end
    end
    m_stop();
    wait_q();
    model_regs[8'h41] = 8'h10;
    model_ptr = 8'h42;
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL write1_strobe_count: got %0d expected 1", obs_q.size()); end
    else begin
      n_checks++; if (obs_q[0] !== 16'h4110) begin n_fail++; $display("FAIL write1_strobe_data: got %h expected 4110", obs_q[0]); end
    end
    n_checks++; if ({wr_addr, wr_data} !== 16'h4110) begin n_fail++; $display("FAIL write1_outputs: got %h expected 4110", {wr_addr, wr_data}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write1_busy_after_stop: got %b expected 0", busy); end
    q = 10;
  endtask

  task automatic test_burst_wrap();
    logic a;
    logic [7:0]  seq [5] = '{8'h72, 8'hFE, 8'hAA, 8'hBB, 8'hCC};
    logic [15:0] exp [3] = '{16'hFEAA, 16'hFFBB, 16'h00CC};
    obs_q.delete();
    m_start();
    for (int i = 0; i < 5; i++) begin
      m_wbyte(seq[i], a);
      n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL burst_ack[%0d]: got ack=%b expected 1", i, a); end
    end
    m_stop();
    wait_q();
    model_regs[8'hFE] = 8'hAA; model_regs[8'hFF] = 8'hBB; model_regs[8'h00] = 8'hCC;
    model_ptr = 8'h01;
    n_checks++; if (obs_q.size() != 3) begin n_fail++; $display("FAIL burst_strobe_count: got %0d expected 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp[i]) begin n_fail++; $display("FAIL burst_strobe[%0d]: got %h expected %h", i, obs_q[i], exp[i]); end
    end
  endtask

  task automatic test_read();
    logic a;
    logic [7:0] d, e;
    m_start();
    m_wbyte(8'h72, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL read_addr_w_ack: got %b expected 1", a); end
    m_wbyte(8'h41, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL read_index_ack: got %b expected 1", a); end
    m_start();
    m_wbyte(8'h73, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL read_addr_r_ack: got %b expected 1", a); end
    m_rbyte(d, 1'b1);
    n_checks++; if (d !== 8'h10) begin n_fail++; $display("FAIL read_byte0: got %h expected 10", d); end
    m_rbyte(d, 1'b0);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL read_byte1: got %h expected 00", d); end
    wait_q();
    n_checks++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL read_sda_after_nack: got %b expected 1", sda_bus); end
    m_stop();
    wait_q();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_after_stop: got %b expected 0", busy); end
    model_ptr = 8'h42;

    // Read across the 0xFF -> 0x00 wrap.
    m_start();
    m_wbyte(8'h72, a);
    m_wbyte(8'hFE, a);
    model_ptr = 8'hFE;
    m_start();
    m_wbyte(8'h73, a);
    for (int i = 0; i < 4; i++) begin
      m_rbyte(d, i < 3);
      e = model_regs[model_ptr];
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL read_wrap[%0d]: got %h expected %h", i, d, e); end
      if (i < 3) model_ptr = model_ptr + 8'd1;
    end
    m_stop();
  endtask

  task automatic test_random();
    logic a;
    logic [7:0] idx, d, e;
    int n;
    for (int t = 0; t < 8; t++) begin
      idx = 8'($urandom);
      n = $urandom_range(1, 3);
      obs_q.delete();
      exp_q.delete();
      m_start();
      m_wbyte(8'h72, a);
      n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL rand%0d_addr_ack: got %b expected 1", t, a); end
      m_wbyte(idx, a);
      model_ptr = idx;
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          m_wbyte(d, a);
          n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL rand%0d_data_ack[%0d]: got %b expected 1", t, k, a); end
          exp_q.push_back({model_ptr, d});
          model_regs[model_ptr] = d;
          model_ptr = model_ptr + 8'd1;
        end
        m_stop();
        wait_q();
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_strobe_count: got %0d expected %0d", t, obs_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
          n_checks++; if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand%0d_strobe[%0d]: got %h expected %h", t, k, obs_q[k], exp_q[k]); end
        end
      end else begin
        m_start();
        m_wbyte(8'h73, a);
        for (int k = 0; k < n; k++) begin
          m_rbyte(d, k < n - 1);
          e = model_regs[model_ptr];
          n_checks++; if (d !== e) begin n_fail++; $display("FAIL rand%0d_read[%0d]: got %h expected %h", t, k, d, e); end
          if (k < n - 1) model_ptr = model_ptr + 8'd1;
        end
        m_stop();
        wait_q();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_busy: got %b expected 0", t, busy); end
      end
    end
  endtask

  task automatic test_wrong_addr();
    logic a;
    int base;
    logic [7:0] seq [5] = '{8'h74, 8'h41, 8'h55, 8'h00, 8'h12};
    obs_q.delete();
    base = dut_low_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i == 0 || i == 3) m_start();
      m_wbyte(seq[i], a);
      n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_ack[%0d]: got ack=%b expected 0", i, a); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_busy[%0d]: got %b expected 0", i, busy); end
      if (i == 2 || i == 4) m_stop();
    end
    wait_q();
    n_checks++; if (dut_low_cnt != base) begin n_fail++; $display("FAIL wrong_addr_sda_driven: got %0d low cycles expected 0", dut_low_cnt - base); end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL wrong_addr_strobe: got %0d strobes expected 0", obs_q.size()); end
  endtask

  task automatic test_abort();
    logic a;
    logic [7:0] d;
    obs_q.delete();
    m_start();
    m_wbyte(8'h72, a);
    m_wbyte(8'h20, a);
    model_ptr = 8'h20;
    m_bit_w(1'b1); m_bit_w(1'b0); m_bit_w(1'b1); m_bit_w(1'b0);
    m_stop();
    wait_q();
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL abort_strobe: got %0d strobes expected 0", obs_q.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    m_start();
    m_wbyte(8'h72, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL abort_next_ack: got %b expected 1", a); end
    m_wbyte(8'h20, a);
    m_wbyte(8'h5A, a);
    m_stop();
    wait_q();
    model_regs[8'h20] = 8'h5A;
    model_ptr = 8'h21;
    n_checks++; if (obs_q.size() != 1 || obs_q[0] !== 16'h205A) begin n_fail++; $display("FAIL abort_next_write: got %0d strobes first=%h expected 1 strobe 205a", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 16'hxxxx); end
    m_start();
    m_wbyte(8'h72, a);
    m_wbyte(8'h20, a);
    m_start();
    m_wbyte(8'h73, a);
    m_rbyte(d, 1'b0);
    m_stop();
    n_checks++; if (d !== model_regs[8'h20]) begin n_fail++; $display("FAIL abort_readback: got %h expected %h", d, model_regs[8'h20]); end
  endtask

  task automatic test_reset_mid();
    logic a;
    logic [7:0] d;
    m_start();
    m_wbyte(8'h72, a);
    m_wbyte(8'h30, a);
    m_wbyte(8'h12, a);
    m_stop();
    m_start();
    m_wbyte(8'h72, a);
    m_wbyte(8'h30, a);
    m_start();
    m_wbyte(8'h73, a);
    n_checks++; if (sda_bus !== 1'b0) begin n_fail++; $display("FAIL midreset_msb_driven: got %b expected 0", sda_bus); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
    model_ptr = 8'h00;
    n_checks++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL midreset_sda: got %b expected 1", sda_bus); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++; if ({wr_strobe, wr_addr, wr_data} !== 17'h0) begin n_fail++; $display("FAIL midreset_outputs: got %h expected 0", {wr_strobe, wr_addr, wr_data}); end
    scl = 1'b1;
    wait_q(); wait_q();
    m_start();
    m_wbyte(8'h72, a);
    m_wbyte(8'h30, a);
    model_ptr = 8'h30;
    m_start();
    m_wbyte(8'h73, a);
    m_rbyte(d, 1'b0);
    m_stop();
    n_checks++; if (d !== model_regs[8'h30]) begin n_fail++; $display("FAIL midreset_reg_cleared: got %h expected %h", d, model_regs[8'h30]); end
  endtask

  task automatic test_drive_rule();
    n_checks++; if (rule_viol != 0) begin n_fail++; $display("FAIL sda_change_while_scl_high: got %0d events expected 0", rule_viol); end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_burst_wrap();
    test_read();
    test_random();
    test_wrong_addr();
    test_abort();
    test_reset_mid();
    test_drive_rule();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
